// File: rtl/tilelink_nto1_arbiter.sv
// TileLink-UL N-to-1 arbiter: round-robin on channel A with Put-burst
// grant locking, registered A output, source-decoded combinational D demux.
`timescale 1ns/1ps
module tilelink_nto1_arbiter #(
    parameter  int M     = 2,
    parameter  int TL_DW = 32,
    parameter  int TL_AW = 32,
    parameter  int TL_RS = 4,
    parameter  int TL_SZ = 4,
    localparam int IW    = $clog2(M),
    localparam int BB    = TL_DW / 8
) (
    input  logic                  tilelink_clock_i,
    input  logic                  tilelink_reset_i,
    input  logic [3*M-1:0]        master_a_opcode,
    input  logic [3*M-1:0]        master_a_param,
    input  logic [M*TL_SZ-1:0]    master_a_size,
    input  logic [M*TL_RS-1:0]    master_a_source,
    input  logic [M*TL_AW-1:0]    master_a_address,
    input  logic [M*BB-1:0]       master_a_mask,
    input  logic [M*TL_DW-1:0]    master_a_data,
    input  logic [M-1:0]          master_a_corrupt,
    input  logic [M-1:0]          master_a_valid,
    output logic [M-1:0]          master_a_ready,
    output logic [2:0]            master_d_opcode,
    output logic [1:0]            master_d_param,
    output logic [TL_SZ-1:0]      master_d_size,
    output logic [TL_RS-1:0]      master_d_source,
    output logic                  master_d_denied,
    output logic                  master_d_corrupt,
    output logic [TL_DW-1:0]      master_d_data,
    output logic [M-1:0]          master_d_valid,
    input  logic [M-1:0]          master_d_ready,
    output logic [2:0]            slave_a_opcode,
    output logic [2:0]            slave_a_param,
    output logic [TL_SZ-1:0]      slave_a_size,
    output logic [TL_RS+IW-1:0]   slave_a_source,
    output logic [TL_AW-1:0]      slave_a_address,
    output logic [BB-1:0]         slave_a_mask,
    output logic [TL_DW-1:0]      slave_a_data,
    output logic                  slave_a_corrupt,
    output logic                  slave_a_valid,
    input  logic                  slave_a_ready,
    input  logic [2:0]            slave_d_opcode,
    input  logic [1:0]            slave_d_param,
    input  logic [TL_SZ-1:0]      slave_d_size,
    input  logic [TL_RS+IW-1:0]   slave_d_source,
    input  logic                  slave_d_denied,
    input  logic                  slave_d_corrupt,
    input  logic                  slave_d_valid,
    input  logic [TL_DW-1:0]      slave_d_data,
    output logic                  slave_d_ready
);

    localparam int LBB = $clog2(BB);

    logic                r_a_valid;
    logic [2:0]          r_a_opcode;
    logic [2:0]          r_a_param;
    logic [TL_SZ-1:0]    r_a_size;
    logic [TL_RS+IW-1:0] r_a_source;
    logic [TL_AW-1:0]    r_a_address;
    logic [BB-1:0]       r_a_mask;
    logic [TL_DW-1:0]    r_a_data;
    logic                r_a_corrupt;

    logic [IW-1:0]       r_rr_ptr;
    logic                r_lock;
    logic [IW-1:0]       r_lock_idx;
    logic [12:0]         r_beats_left;

    logic                w_can_load;
    logic                w_accept;
    logic                w_found;
    logic [IW-1:0]       w_idx;
    logic [M-1:0]        w_grant;
    logic                w_hi_found;
    logic [IW-1:0]       w_hi_idx;
    logic                w_lo_found;
    logic [IW-1:0]       w_lo_idx;
    logic [IW-1:0]       w_next_ptr;

    logic [2:0]          w_sel_opcode;
    logic [2:0]          w_sel_param;
    logic [TL_SZ-1:0]    w_sel_size;
    logic [TL_RS-1:0]    w_sel_source;
    logic [TL_AW-1:0]    w_sel_address;
    logic [BB-1:0]       w_sel_mask;
    logic [TL_DW-1:0]    w_sel_data;
    logic                w_sel_corrupt;
    logic                w_is_put;
    logic                w_multi;
    logic [12:0]         w_burst_len;

    logic [IW-1:0]       w_d_idx;
    logic                w_d_hit;

    assign w_can_load = !r_a_valid || slave_a_ready;

    // Round-robin: lowest valid index at/after the pointer, else wrap.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = 0; i < M; i++) begin
            if (master_a_valid[i]) begin
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = IW'(i);
                end
                if (!w_hi_found && (IW'(i) >= r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IW'(i);
                end
            end
        end
        if (r_lock) begin
            w_found = master_a_valid[r_lock_idx];
            w_idx   = r_lock_idx;
        end else if (w_hi_found) begin
            w_found = 1'b1;
            w_idx   = w_hi_idx;
        end else begin
            w_found = w_lo_found;
            w_idx   = w_lo_idx;
        end
    end

    assign w_grant        = w_found ? (M'(1) << w_idx) : '0;
    assign master_a_ready = w_can_load ? w_grant : '0;
    assign w_accept       = w_can_load && w_found;
    assign w_next_ptr     = (w_idx == IW'(M - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_sel_opcode  = '0;
        w_sel_param   = '0;
        w_sel_size    = '0;
        w_sel_source  = '0;
        w_sel_address = '0;
        w_sel_mask    = '0;
        w_sel_data    = '0;
        w_sel_corrupt = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (w_idx == IW'(i)) begin
                w_sel_opcode  = master_a_opcode[i*3 +: 3];
                w_sel_param   = master_a_param[i*3 +: 3];
                w_sel_size    = master_a_size[i*TL_SZ +: TL_SZ];
                w_sel_source  = master_a_source[i*TL_RS +: TL_RS];
                w_sel_address = master_a_address[i*TL_AW +: TL_AW];
                w_sel_mask    = master_a_mask[i*BB +: BB];
                w_sel_data    = master_a_data[i*TL_DW +: TL_DW];
                w_sel_corrupt = master_a_corrupt[i];
            end
        end
    end

    // Only Puts larger than one beat and at most 4 KiB start a locked burst.
    assign w_is_put    = (w_sel_opcode == 3'd0) || (w_sel_opcode == 3'd1);
    assign w_multi     = !r_lock && w_is_put &&
                         (int'(w_sel_size) > LBB) &&
                         (int'(w_sel_size) <= 12);
    assign w_burst_len = 13'((1 << (int'(w_sel_size) - LBB)) - 1);

    always_ff @(posedge tilelink_clock_i) begin
        if (tilelink_reset_i) begin
            r_a_valid    <= 1'b0;
            r_rr_ptr     <= '0;
            r_lock       <= 1'b0;
            r_lock_idx   <= '0;
            r_beats_left <= '0;
        end else if (w_accept) begin
            r_a_valid <= 1'b1;
            if (r_lock) begin
                r_beats_left <= r_beats_left - 13'd1;
                if (r_beats_left == 13'd1) begin
                    r_lock <= 1'b0;
                end
            end else begin
                r_rr_ptr <= w_next_ptr;
                if (w_multi) begin
                    r_lock       <= 1'b1;
                    r_lock_idx   <= w_idx;
                    r_beats_left <= w_burst_len;
                end
            end
        end else if (w_can_load) begin
            r_a_valid <= 1'b0;
        end
    end

    always_ff @(posedge tilelink_clock_i) begin
        if (w_accept) begin
            r_a_opcode  <= w_sel_opcode;
            r_a_param   <= w_sel_param;
            r_a_size    <= w_sel_size;
            r_a_source  <= {w_idx, w_sel_source};
            r_a_address <= w_sel_address;
            r_a_mask    <= w_sel_mask;
            r_a_data    <= w_sel_data;
            r_a_corrupt <= w_sel_corrupt;
        end
    end

    assign slave_a_valid   = r_a_valid;
    assign slave_a_opcode  = r_a_opcode;
    assign slave_a_param   = r_a_param;
    assign slave_a_size    = r_a_size;
    assign slave_a_source  = r_a_source;
    assign slave_a_address = r_a_address;
    assign slave_a_mask    = r_a_mask;
    assign slave_a_data    = r_a_data;
    assign slave_a_corrupt = r_a_corrupt;

    assign w_d_idx = slave_d_source[TL_RS +: IW];

    // Non-power-of-two M leaves source prefixes with no master; sink them.
    if ((1 << IW) == M) begin : g_d_pow2
        assign w_d_hit = 1'b1;
    end else begin : g_d_npow2
        assign w_d_hit = (int'(w_d_idx) < M);
    end

    assign master_d_valid   = (slave_d_valid && w_d_hit) ?
                              (M'(1) << w_d_idx) : '0;
    assign slave_d_ready    = w_d_hit ? master_d_ready[w_d_idx] : 1'b1;
    assign master_d_opcode  = slave_d_opcode;
    assign master_d_param   = slave_d_param;
    assign master_d_size    = slave_d_size;
    assign master_d_source  = slave_d_source[TL_RS-1:0];
    assign master_d_denied  = slave_d_denied;
    assign master_d_corrupt = slave_d_corrupt;
    assign master_d_data    = slave_d_data;

endmodule

// File: tb/tb_tilelink_nto1_arbiter.sv
// Testbench for tilelink_nto1_arbiter: directed scenarios plus a randomized
// run against a transaction-level arbitration model (M=2 and M=3 instances).
`timescale 1ns/1ps
module tb_tilelink_nto1_arbiter;
    localparam int M  = 2;
    localparam int M3 = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RS = 4;
    localparam int SZ = 4;
    localparam int BB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3*M-1:0]  ma_op, ma_pr;
    logic [M*SZ-1:0] ma_sz;
    logic [M*RS-1:0] ma_src;
    logic [M*AW-1:0] ma_addr;
    logic [M*BB-1:0] ma_mask;
    logic [M*DW-1:0] ma_data;
    logic [M-1:0]    ma_cor, ma_valid, ma_ready;
    logic [2:0]      md_op;
    logic [1:0]      md_pr;
    logic [SZ-1:0]   md_sz;
    logic [RS-1:0]   md_src;
    logic            md_den, md_cor;
    logic [DW-1:0]   md_data;
    logic [M-1:0]    md_valid, md_ready;
    logic [2:0]      sa_op, sa_pr;
    logic [SZ-1:0]   sa_sz;
    logic [RS:0]     sa_src;
    logic [AW-1:0]   sa_addr;
    logic [BB-1:0]   sa_mask;
    logic [DW-1:0]   sa_data;
    logic            sa_cor, sa_valid, sa_ready;
    logic [2:0]      sd_op;
    logic [1:0]      sd_pr;
    logic [SZ-1:0]   sd_sz;
    logic [RS:0]     sd_src;
    logic            sd_den, sd_cor, sd_valid, sd_ready;
    logic [DW-1:0]   sd_data;

    logic [3*M3-1:0]  ta_op, ta_pr;
    logic [M3*SZ-1:0] ta_sz;
    logic [M3*RS-1:0] ta_src;
    logic [M3*AW-1:0] ta_addr;
    logic [M3*BB-1:0] ta_mask;
    logic [M3*DW-1:0] ta_data;
    logic [M3-1:0]    ta_cor, ta_valid, ta_ready;
    logic [2:0]       td_op;
    logic [1:0]       td_pr;
    logic [SZ-1:0]    td_sz;
    logic [RS-1:0]    td_src;
    logic             td_den, td_cor;
    logic [DW-1:0]    td_data;
    logic [M3-1:0]    td_valid, td_ready;
    logic [2:0]       tsa_op, tsa_pr;
    logic [SZ-1:0]    tsa_sz;
    logic [RS+1:0]    tsa_src;
    logic [AW-1:0]    tsa_addr;
    logic [BB-1:0]    tsa_mask;
    logic [DW-1:0]    tsa_data;
    logic             tsa_cor, tsa_valid, tsa_ready;
    logic [RS+1:0]    tsd_src;
    logic             tsd_valid, tsd_ready;

    int n_cmp = 0;
    int n_err = 0;

    tilelink_nto1_arbiter #(.M(M), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ)) dut (
        .tilelink_clock_i(clk), .tilelink_reset_i(rst),
        .master_a_opcode(ma_op), .master_a_param(ma_pr), .master_a_size(ma_sz),
        .master_a_source(ma_src), .master_a_address(ma_addr), .master_a_mask(ma_mask),
        .master_a_data(ma_data), .master_a_corrupt(ma_cor), .master_a_valid(ma_valid),
        .master_a_ready(ma_ready),
        .master_d_opcode(md_op), .master_d_param(md_pr), .master_d_size(md_sz),
        .master_d_source(md_src), .master_d_denied(md_den), .master_d_corrupt(md_cor),
        .master_d_data(md_data), .master_d_valid(md_valid), .master_d_ready(md_ready),
        .slave_a_opcode(sa_op), .slave_a_param(sa_pr), .slave_a_size(sa_sz),
        .slave_a_source(sa_src), .slave_a_address(sa_addr), .slave_a_mask(sa_mask),
        .slave_a_data(sa_data), .slave_a_corrupt(sa_cor), .slave_a_valid(sa_valid),
        .slave_a_ready(sa_ready),
        .slave_d_opcode(sd_op), .slave_d_param(sd_pr), .slave_d_size(sd_sz),
        .slave_d_source(sd_src), .slave_d_denied(sd_den), .slave_d_corrupt(sd_cor),
        .slave_d_valid(sd_valid), .slave_d_data(sd_data), .slave_d_ready(sd_ready)
    );

    tilelink_nto1_arbiter #(.M(M3), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ)) dut3 (
        .tilelink_clock_i(clk), .tilelink_reset_i(rst),
        .master_a_opcode(ta_op), .master_a_param(ta_pr), .master_a_size(ta_sz),
        .master_a_source(ta_src), .master_a_address(ta_addr), .master_a_mask(ta_mask),
        .master_a_data(ta_data), .master_a_corrupt(ta_cor), .master_a_valid(ta_valid),
        .master_a_ready(ta_ready),
        .master_d_opcode(td_op), .master_d_param(td_pr), .master_d_size(td_sz),
        .master_d_source(td_src), .master_d_denied(td_den), .master_d_corrupt(td_cor),
        .master_d_data(td_data), .master_d_valid(td_valid), .master_d_ready(td_ready),
        .slave_a_opcode(tsa_op), .slave_a_param(tsa_pr), .slave_a_size(tsa_sz),
        .slave_a_source(tsa_src), .slave_a_address(tsa_addr), .slave_a_mask(tsa_mask),
        .slave_a_data(tsa_data), .slave_a_corrupt(tsa_cor), .slave_a_valid(tsa_valid),
        .slave_a_ready(tsa_ready),
        .slave_d_opcode(sd_op), .slave_d_param(sd_pr), .slave_d_size(sd_sz),
        .slave_d_source(tsd_src), .slave_d_denied(sd_den), .slave_d_corrupt(sd_cor),
        .slave_d_valid(tsd_valid), .slave_d_data(sd_data), .slave_d_ready(tsd_ready)
    );

    logic [83:0] sa_pack;
    assign sa_pack = {sa_op, sa_pr, sa_sz, sa_src, sa_addr, sa_mask, sa_data, sa_cor};

    // Expected slave-side beat for master i, built from what the bench drives.
    function automatic logic [83:0] exp_beat(input int i);
        return {ma_op[i*3 +: 3], ma_pr[i*3 +: 3], ma_sz[i*SZ +: SZ], 1'(i),
                ma_src[i*RS +: RS], ma_addr[i*AW +: AW], ma_mask[i*BB +: BB],
                ma_data[i*DW +: DW], ma_cor[i]};
    endfunction

    task automatic drive_a(input int i, input logic [2:0] op, input logic [3:0] sz,
                           input logic [3:0] src, input logic [31:0] d, input logic v);
        ma_op[i*3 +: 3]     = op;
        ma_pr[i*3 +: 3]     = d[7:5];
        ma_sz[i*SZ +: SZ]   = sz;
        ma_src[i*RS +: RS]  = src;
        ma_addr[i*AW +: AW] = {16'hA000, d[31:16]};
        ma_mask[i*BB +: BB] = d[3:0];
        ma_data[i*DW +: DW] = d;
        ma_cor[i]           = d[8];
        ma_valid[i]         = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ma_op = '0; ma_pr = '0; ma_sz = '0; ma_src = '0; ma_addr = '0;
        ma_mask = '0; ma_data = '0; ma_cor = '0; ma_valid = '0;
        ta_op = '0; ta_pr = '0; ta_sz = '0; ta_src = '0; ta_addr = '0;
        ta_mask = '0; ta_data = '0; ta_cor = '0; ta_valid = '0;
        md_ready = '0; td_ready = '0; sa_ready = 1'b1; tsa_ready = 1'b1;
        sd_op = '0; sd_pr = '0; sd_sz = '0; sd_src = '0; sd_den = 0; sd_cor = 0;
        sd_data = '0; sd_valid = 0; tsd_src = '0; tsd_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (sa_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_sa_valid got=%b exp=0", sa_valid);
        end
        n_cmp++;
        if (ma_ready !== 2'b00) begin
            n_err++; $display("FAIL reset_ma_ready got=%b exp=00", ma_ready);
        end
        n_cmp++;
        if (md_valid !== 2'b00) begin
            n_err++; $display("FAIL reset_md_valid got=%b exp=00", md_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_rr_get();
        logic [83:0] e;
        drive_a(0, 3'd4, 4'd2, 4'h3, $urandom, 1'b1);
        drive_a(1, 3'd4, 4'd2, 4'h5, $urandom, 1'b1);
        #1;
        n_cmp++;
        if (ma_ready !== 2'b01) begin
            n_err++; $display("FAIL rr_first_grant got=%b exp=01", ma_ready);
        end
        e = exp_beat(0);
        @(posedge clk); #1;
        n_cmp++;
        if (sa_valid !== 1'b1 || sa_src !== 5'h03 || sa_pack !== e) begin
            n_err++; $display("FAIL rr_beat0 got=%h exp=%h v=%b", sa_pack, e, sa_valid);
        end
        n_cmp++;
        if (ma_ready !== 2'b10) begin
            n_err++; $display("FAIL rr_second_grant got=%b exp=10", ma_ready);
        end
        e = exp_beat(1);
        @(posedge clk); #1;
        n_cmp++;
        if (sa_src !== 5'h15 || sa_pack !== e) begin
            n_err++; $display("FAIL rr_beat1 got=%h exp=%h", sa_pack, e);
        end
        ma_valid = '0;
        @(posedge clk); #1;
        n_cmp++;
        if (sa_valid !== 1'b0) begin
            n_err++; $display("FAIL rr_drain got=%b exp=0", sa_valid);
        end
    endtask

    task automatic test_burst_lock();
        logic [83:0] e;
        ma_valid = '0;
        drive_a(1, 3'd0, 4'd4, 4'h9, $urandom, 1'b1);
        #1;
        n_cmp++;
        if (ma_ready !== 2'b10) begin
            n_err++; $display("FAIL burst_start got=%b exp=10", ma_ready);
        end
        e = exp_beat(1);
        for (int b = 1; b < 4; b++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (sa_valid !== 1'b1 || sa_pack !== e) begin
                n_err++; $display("FAIL burst_beat%0d got=%h exp=%h", b - 1, sa_pack, e);
            end
            drive_a(1, 3'd0, 4'd4, 4'h9, $urandom, 1'b1);
            drive_a(0, 3'd4, 4'd0, 4'h2, $urandom, 1'b1);
            #1;
            n_cmp++;
            if (ma_ready !== 2'b10) begin
                n_err++; $display("FAIL burst_locked%0d got=%b exp=10", b, ma_ready);
            end
            e = exp_beat(1);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (sa_pack !== e) begin
            n_err++; $display("FAIL burst_beat3 got=%h exp=%h", sa_pack, e);
        end
        drive_a(1, 3'd4, 4'd0, 4'h9, $urandom, 1'b1);
        #1;
        n_cmp++;
        if (ma_ready !== 2'b01) begin
            n_err++; $display("FAIL burst_release got=%b exp=01", ma_ready);
        end
        e = exp_beat(0);
        @(posedge clk); #1;
        n_cmp++;
        if (sa_pack !== e) begin
            n_err++; $display("FAIL burst_after got=%h exp=%h", sa_pack, e);
        end
        ma_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [83:0] e;
        @(posedge clk); #1;
        drive_a(0, 3'd1, 4'd2, 4'h4, $urandom, 1'b1);
        sa_ready = 1'b1;
        #1;
        e = exp_beat(0);
        @(posedge clk); #1;
        sa_ready = 1'b0;
        drive_a(0, 3'd1, 4'd2, 4'h4, $urandom, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (ma_ready !== 2'b00 || sa_valid !== 1'b1 || sa_pack !== e) begin
                n_err++;
                $display("FAIL bp_hold%0d rdy=%b v=%b got=%h exp=%h", k, ma_ready, sa_valid, sa_pack, e);
            end
            @(posedge clk); #1;
        end
        sa_ready = 1'b1;
        #1;
        n_cmp++;
        if (ma_ready !== 2'b01) begin
            n_err++; $display("FAIL bp_release got=%b exp=01", ma_ready);
        end
        e = exp_beat(0);
        @(posedge clk); #1;
        n_cmp++;
        if (sa_pack !== e) begin
            n_err++; $display("FAIL bp_beat1 got=%h exp=%h", sa_pack, e);
        end
        drive_a(0, 3'd1, 4'd2, 4'h4, $urandom, 1'b1);
        #1;
        e = exp_beat(0);
        @(posedge clk); #1;
        n_cmp++;
        if (sa_valid !== 1'b1 || sa_pack !== e) begin
            n_err++; $display("FAIL bp_beat2 got=%h exp=%h", sa_pack, e);
        end
        ma_valid = '0;
        @(posedge clk); #1;
        n_cmp++;
        if (sa_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drain got=%b exp=0", sa_valid);
        end
    endtask

    task automatic test_d_route();
        logic [31:0] d;
        d = $urandom;
        sd_data = d; sd_op = 3'd1; sd_pr = 2'd2; sd_sz = 4'd2; sd_den = 1'b0; sd_cor = 1'b1;
        sd_src = 5'h17; sd_valid = 1'b1; md_ready = 2'b00;
        #1;
        n_cmp++;
        if (md_valid !== 2'b10 || md_src !== 4'h7 || sd_ready !== 1'b0) begin
            n_err++; $display("FAIL d_route v=%b src=%h rdy=%b exp 10/7/0", md_valid, md_src, sd_ready);
        end
        n_cmp++;
        if (md_data !== d || md_op !== 3'd1 || md_pr !== 2'd2 || md_cor !== 1'b1) begin
            n_err++; $display("FAIL d_pass got=%h exp=%h", md_data, d);
        end
        md_ready = 2'b10;
        #1;
        n_cmp++;
        if (sd_ready !== 1'b1) begin
            n_err++; $display("FAIL d_ready_rise got=%b exp=1", sd_ready);
        end
        md_ready = 2'b01;
        #1;
        n_cmp++;
        if (sd_ready !== 1'b0) begin
            n_err++; $display("FAIL d_ready_other got=%b exp=0", sd_ready);
        end
        sd_src = 5'h02;
        #1;
        n_cmp++;
        if (md_valid !== 2'b01 || sd_ready !== 1'b1 || md_src !== 4'h2) begin
            n_err++; $display("FAIL d_route0 v=%b rdy=%b exp 01/1", md_valid, sd_ready);
        end
        sd_valid = 1'b0;
        #1;
        n_cmp++;
        if (md_valid !== 2'b00) begin
            n_err++; $display("FAIL d_idle got=%b exp=00", md_valid);
        end
    endtask

    task automatic test_d_oob();
        tsd_valid = 1'b1; tsd_src = 6'h32; td_ready = 3'b000;
        #1;
        n_cmp++;
        if (tsd_ready !== 1'b1 || td_valid !== 3'b000) begin
            n_err++; $display("FAIL d_oob rdy=%b v=%b exp 1/000", tsd_ready, td_valid);
        end
        tsd_src = 6'h25;
        #1;
        n_cmp++;
        if (td_valid !== 3'b100 || tsd_ready !== 1'b0 || td_src !== 4'h5) begin
            n_err++; $display("FAIL d_idx2 v=%b rdy=%b exp 100/0", td_valid, tsd_ready);
        end
        td_ready = 3'b100;
        #1;
        n_cmp++;
        if (tsd_ready !== 1'b1) begin
            n_err++; $display("FAIL d_idx2_rdy got=%b exp=1", tsd_ready);
        end
        tsd_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [83:0] e;
        @(posedge clk); #1;
        ma_valid = '0; sa_ready = 1'b1;
        drive_a(1, 3'd0, 4'd4, 4'h6, $urandom, 1'b1);
        @(posedge clk); #1;
        drive_a(1, 3'd0, 4'd4, 4'h6, $urandom, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if (sa_valid !== 1'b1) begin
            n_err++; $display("FAIL rmb_pre got=%b exp=1", sa_valid);
        end
        rst = 1'b1;
        drive_a(0, 3'd4, 4'd0, 4'h1, $urandom, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if (sa_valid !== 1'b0) begin
            n_err++; $display("FAIL rmb_valid got=%b exp=0", sa_valid);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ma_ready !== 2'b01) begin
            n_err++; $display("FAIL rmb_grant got=%b exp=01", ma_ready);
        end
        e = exp_beat(0);
        @(posedge clk); #1;
        n_cmp++;
        if (sa_pack !== e) begin
            n_err++; $display("FAIL rmb_beat got=%h exp=%h", sa_pack, e);
        end
        ma_valid = '0;
    endtask

    task automatic test_random();
        int          rr, owner, left, g;
        logic        ov, canl;
        logic [83:0] ob;
        logic [M-1:0] er;
        int tx_left[M], tx_op[M], tx_sz[M], tx_src[M];
        rst = 1'b1; ma_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        rr = 0; owner = -1; left = 0; ov = 1'b0; ob = '0;
        for (int i = 0; i < M; i++) tx_left[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < M; i++) begin
                if (tx_left[i] == 0) begin
                    int r, r2;
                    r  = $urandom % 8;
                    tx_op[i] = (r < 3) ? 0 : (r == 3) ? 1 : (r < 6) ? 4 : (r == 6) ? 2 : 3;
                    tx_src[i] = $urandom % 16;
                    if (tx_op[i] <= 1) begin
                        r2 = $urandom % 8;
                        tx_sz[i] = (r2 < 6) ? 2 + $urandom % 4 :
                                   (r2 == 6) ? $urandom % 3 : 13 + $urandom % 3;
                    end else begin
                        tx_sz[i] = $urandom % 16;
                    end
                    tx_left[i] = (tx_op[i] <= 1 && tx_sz[i] > 2 && tx_sz[i] <= 12) ?
                                 (1 << tx_sz[i]) / BB : 1;
                end
                drive_a(i, 3'(tx_op[i]), 4'(tx_sz[i]), 4'(tx_src[i]), $urandom,
                        ($urandom % 4) != 0);
            end
            sa_ready = ($urandom % 4) != 0;
            sd_src = 5'($urandom); sd_valid = 1'($urandom); md_ready = 2'($urandom);
            sd_data = $urandom; sd_op = 3'($urandom); sd_pr = 2'($urandom);
            sd_sz = 4'($urandom); sd_den = 1'($urandom); sd_cor = 1'($urandom);
            tsd_src = 6'($urandom); tsd_valid = 1'($urandom); td_ready = 3'($urandom);
            #1;
            n_cmp++;
            if (sa_valid !== ov || (ov && sa_pack !== ob)) begin
                n_err++; $display("FAIL rnd_a_out cyc=%0d v=%b got=%h exp v=%b %h", cyc, sa_valid, sa_pack, ov, ob);
            end
            g = -1;
            if (owner >= 0) begin
                if (ma_valid[owner]) g = owner;
            end else begin
                for (int k = 0; k < M; k++)
                    if (g < 0 && ma_valid[(rr + k) % M]) g = (rr + k) % M;
            end
            canl = !ov || sa_ready;
            er = '0;
            if (canl && g >= 0) er[g] = 1'b1;
            n_cmp++;
            if (ma_ready !== er) begin
                n_err++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, ma_ready, er);
            end
            n_cmp++;
            if (md_valid !== (sd_valid ? (2'b01 << sd_src[4]) : 2'b00) ||
                sd_ready !== md_ready[sd_src[4]] || md_src !== sd_src[3:0] ||
                {md_op, md_pr, md_sz, md_den, md_cor, md_data} !==
                {sd_op, sd_pr, sd_sz, sd_den, sd_cor, sd_data}) begin
                n_err++; $display("FAIL rnd_d2 cyc=%0d v=%b rdy=%b src=%h", cyc, md_valid, sd_ready, sd_src);
            end
            n_cmp++;
            if (tsd_src[5:4] == 2'd3) begin
                if (td_valid !== 3'b000 || tsd_ready !== 1'b1) begin
                    n_err++; $display("FAIL rnd_d3_oob cyc=%0d v=%b rdy=%b", cyc, td_valid, tsd_ready);
                end
            end else if (td_valid !== (tsd_valid ? (3'b001 << tsd_src[5:4]) : 3'b000) ||
                         tsd_ready !== td_ready[tsd_src[5:4]]) begin
                n_err++; $display("FAIL rnd_d3 cyc=%0d v=%b rdy=%b src=%h", cyc, td_valid, tsd_ready, tsd_src);
            end
            if (canl && g >= 0) begin
                ob = exp_beat(g);
                ov = 1'b1;
                if (owner < 0) begin
                    rr = (g + 1) % M;
                    if (tx_left[g] > 1) begin
                        owner = g;
                        left  = tx_left[g] - 1;
                    end
                end else begin
                    left--;
                    if (left == 0) owner = -1;
                end
                tx_left[g]--;
            end else if (canl) begin
                ov = 1'b0;
            end
            @(posedge clk); #1;
        end
        ma_valid = '0; sd_valid = 1'b0; tsd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_get();
        test_burst_lock();
        test_backpressure();
        test_d_route();
        test_d_oob();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tilelink_nto1_arbiter.md
# tilelink_nto1_arbiter

Shares one TileLink-UL slave port between M masters, the upstream companion to the 1-to-N address demux. Round-robin arbitration on channel A, with grant locking for the full length of multi-beat Put bursts. The winning master index is prepended to the A source so that channel-D responses route back by source decode. Channel A has one registered beat of latency; channel D is a combinational demux.

## Interface
- M, 2, number of masters (≥2); IW = $clog2(M)
- TL_DW, 32, data width in bits; BB = TL_DW/8 bytes per beat
- TL_AW, 32, address width
- TL_RS, 4, master-side source width; slave-side source width is TL_RS+IW
- TL_SZ, 4, size field width
- tilelink_clock_i  in  1  the one clock
- tilelink_reset_i  in  1  synchronous, active-high reset
- master_a_opcode/param  in  3*M each  per-master A opcode/param, master i at bits [3i+2:3i]
- master_a_size  in  M*TL_SZ; master_a_source  in  M*TL_RS; master_a_address  in  M*TL_AW
- master_a_mask  in  M*BB; master_a_data  in  M*TL_DW; master_a_corrupt, master_a_valid  in  M
- master_a_ready  out  M  beat accept per master
- master_d_opcode  out  3; master_d_param  out  2; master_d_size  out  TL_SZ; master_d_source  out  TL_RS
- master_d_denied, master_d_corrupt  out  1; master_d_data  out  TL_DW  broadcast to all masters
- master_d_valid  out  M  one-hot response valid; master_d_ready  in  M
- slave_a_opcode/param  out  3; slave_a_size  out  TL_SZ; slave_a_source  out  TL_RS+IW
- slave_a_address  out  TL_AW; slave_a_mask  out  BB; slave_a_data  out  TL_DW; slave_a_corrupt, slave_a_valid  out  1
- slave_a_ready  in  1
- slave_d_opcode  in  3; slave_d_param  in  2; slave_d_size  in  TL_SZ; slave_d_source  in  TL_RS+IW
- slave_d_denied, slave_d_corrupt, slave_d_valid  in  1; slave_d_data  in  TL_DW; slave_d_ready  out  1

## Operation
- State: output register (slave_a_*), rr_ptr [IW-1:0], lock, lock_idx [IW-1:0], beats_left [12:0].
- can_load = !slave_a_valid | slave_a_ready.
- Grant, unlocked: the first i with master_a_valid[i], scanning rr_ptr, rr_ptr+1, ... mod M. Locked: i = lock_idx only, and only if it is valid.
- master_a_ready[i] = can_load & grant[i]. At most one bit is set; it is combinational.
- On accept: register all A fields of master i; slave_a_source = {i[IW-1:0], master_a_source_i}; slave_a_valid <= 1.
- If can_load and there is no accept: slave_a_valid <= 0. Otherwise the register holds.
- Multi-beat detection on an unlocked accept: opcode ∈ {0 PutFull, 1 PutPartial} and size > log2(BB) and size ≤ 12. Then:
  - lock <= 1, lock_idx <= i
  - beats_left <= (2^size)/BB - 1
- Locked accept: beats_left decrements. On the accept that finds beats_left==1, lock <= 0 and the counter reaches 0.
- rr_ptr <= (i+1) mod M on every unlocked accept, including single-beat ones. rr_ptr is not updated during locked beats.
- Get (opcode 4) is always single-beat on A, regardless of size.
- Size > 12 is treated as single-beat.
- D routing: idx = slave_d_source[TL_RS+IW-1:TL_RS].
  - master_d_valid = slave_d_valid << idx.
  - slave_d_ready = master_d_ready[idx].
  - master_d_source = slave_d_source[TL_RS-1:0]; all other D fields pass through.
- D with idx ≥ M: slave_d_ready = 1, master_d_valid = 0, beat discarded.
- The slave returns D bursts contiguously, so no D arbitration or locking is required.

## Timing
- Reset values: slave_a_valid 0, lock 0, lock_idx 0, beats_left 0, rr_ptr 0 (master 0 has first priority). slave_a_* payload is don't-care.
- Combinational outputs (master_a_ready, master_d_*, slave_d_ready) follow inputs in the same cycle.
- A latency: accept at cycle t → beat on slave_a_* at t+1.
- Throughput is 1 beat/cycle while slave_a_ready = 1.
- slave_a_* stay stable while slave_a_valid & !slave_a_ready.
- Simultaneous drain and load (slave_a_ready=1 and a new accept): the new beat replaces the old one with no bubble.
- Locked master deasserts valid mid-burst: no beat is issued and other masters stay blocked until the burst completes.
- Reset asserted mid-burst clears lock in the next cycle. The partial burst is abandoned; the slave must also be reset.

## Test plan
- M=2, both masters valid with a single-beat Get from reset → master 0 granted at t0, master 1 at t0+1; slave_a_source = {0,src0} then {1,src1}.
- Master 1 issues PutFull size=4 (16 B, 4 beats) while master 0 is valid → 4 consecutive beats from master 1 with master_a_ready[0]=0 throughout; master 0 is granted on the 5th cycle.
- slave_a_ready held low for 3 cycles with slave_a_valid=1 → slave_a_* unchanged and master_a_ready=0; 1 beat/cycle resumes after release.
- D beat with slave_d_source = {1,4'h7}, master_d_ready[1]=0 → master_d_valid=2'b10, master_d_source=4'h7, slave_d_ready=0; it becomes 1 when master_d_ready[1] rises.
- M=3, D beat with idx=3 → slave_d_ready=1 and master_d_valid=0.
- Reset asserted after 2 of 4 burst beats → lock=0 and slave_a_valid=0 next cycle; rr_ptr=0, and master 0 wins the next grant.
